// File: rtl/cci_mpf_csr_mmio_seq.sv
// rtl/cci_mpf_csr_mmio_seq.sv - MPF CSR block: MMIO register writes, queued in-order read responses, event counters
//
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   mmio_wr_valid/idx/data                host CSR write (no flow control)
//   mmio_rd_valid/idx/tid                 host CSR read (no flow control), queued in a FIFO
//   rsp_ready, rsp_valid/tid/data         read response channel
//   vtp_mode                              page-table mode register
//   vtp_pt_base, vtp_pt_base_valid        page-table base line address, one-cycle update pulse
//   vc_map_ctrl, vc_map_ctrl_valid        VC map control, one-cycle update pulse
//   vc_map_history, wro_stats             read-only status inputs
//   events                                per-cycle event strobes counted by 7 counters
//   rd_overflow                           sticky: a read request was dropped on a full FIFO
module cci_mpf_csr_mmio_seq #(
  parameter int RD_FIFO_DEPTH = 4,
  parameter int CTR_WIDTH     = 48
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mmio_wr_valid,
  input  logic [3:0]       mmio_wr_idx,
  input  logic [63:0]      mmio_wr_data,
  input  logic             mmio_rd_valid,
  input  logic [3:0]       mmio_rd_idx,
  input  logic [8:0]       mmio_rd_tid,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output logic [8:0]       rsp_tid,
  output logic [63:0]      rsp_data,
  output logic [63:0]      vtp_mode,
  output logic [41:0]      vtp_pt_base,
  output logic             vtp_pt_base_valid,
  output logic [63:0]      vc_map_ctrl,
  output logic             vc_map_ctrl_valid,
  input  logic [63:0]      vc_map_history,
  input  logic [3:0][63:0] wro_stats,
  input  logic [6:0]       events,
  output logic             rd_overflow
);

  localparam int PW = $clog2(RD_FIFO_DEPTH);

  logic [12:0]          fifo_mem [RD_FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          count;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic [12:0]          head;
  logic [3:0]           head_idx;
  logic [63:0]          rd_data;
  logic [6:0]           ctr_clr;
  logic [CTR_WIDTH-1:0] ctr [7];

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(RD_FIFO_DEPTH));
  assign pop   = !empty && rsp_ready;
  // A full FIFO still accepts a request when the head leaves in the same cycle.
  assign push  = mmio_rd_valid && (!full || pop);

  assign head     = fifo_mem[rd_ptr];
  assign head_idx = head[12:9];

  assign ctr_clr = (mmio_wr_valid && mmio_wr_idx == 4'd15) ? mmio_wr_data[6:0] : 7'd0;

  // Read data is sampled at pop time, so a write landing in the request's
  // arrival cycle is already visible here.
  always_comb begin
    rd_data = '0;
    case (head_idx)
      4'd0:                   rd_data = vtp_mode;
      4'd1:                   rd_data = 64'(vtp_pt_base);
      4'd2:                   rd_data = vc_map_ctrl;
      4'd3:                   rd_data = vc_map_history;
      4'd4, 4'd5, 4'd6, 4'd7: rd_data = wro_stats[head_idx[1:0]];
      4'd15:                  rd_data = '0;
      default:                rd_data = 64'(ctr[head_idx[2:0]]);
    endcase
  end

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {mmio_rd_idx, mmio_rd_tid};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_overflow <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_tid     <= '0;
      rsp_data    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mmio_rd_valid && !push) rd_overflow <= 1'b1;
      rsp_valid <= pop;
      if (pop) begin
        rsp_tid  <= head[8:0];
        rsp_data <= rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vtp_mode          <= '0;
      vtp_pt_base       <= '0;
      vtp_pt_base_valid <= 1'b0;
      vc_map_ctrl       <= '0;
      vc_map_ctrl_valid <= 1'b0;
    end else begin
      vtp_pt_base_valid <= mmio_wr_valid && (mmio_wr_idx == 4'd1);
      vc_map_ctrl_valid <= mmio_wr_valid && (mmio_wr_idx == 4'd2);
      if (mmio_wr_valid) begin
        case (mmio_wr_idx)
          4'd0:    vtp_mode    <= mmio_wr_data;
          4'd1:    vtp_pt_base <= mmio_wr_data[41:0];
          4'd2:    vc_map_ctrl <= mmio_wr_data;
          default: ;
        endcase
      end
    end
  end

  // Clear takes priority over a same-cycle event; counters wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 7; i++) ctr[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (ctr_clr[i])     ctr[i] <= '0;
        else if (events[i]) ctr[i] <= ctr[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_csr_mmio_seq.sv
// tb/tb_cci_mpf_csr_mmio_seq.sv - directed scoreboard bench for cci_mpf_csr_mmio_seq
module tb_cci_mpf_csr_mmio_seq;

  localparam int CTR_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             mmio_wr_valid;
  logic [3:0]       mmio_wr_idx;
  logic [63:0]      mmio_wr_data;
  logic             mmio_rd_valid;
  logic [3:0]       mmio_rd_idx;
  logic [8:0]       mmio_rd_tid;
  logic             rsp_ready;
  logic             rsp_valid;
  logic [8:0]       rsp_tid;
  logic [63:0]      rsp_data;
  logic [63:0]      vtp_mode;
  logic [41:0]      vtp_pt_base;
  logic             vtp_pt_base_valid;
  logic [63:0]      vc_map_ctrl;
  logic             vc_map_ctrl_valid;
  logic [63:0]      vc_map_history;
  logic [3:0][63:0] wro_stats;
  logic [6:0]       events;
  logic             rd_overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [72:0] sb [$];

  cci_mpf_csr_mmio_seq #(.RD_FIFO_DEPTH(4), .CTR_WIDTH(CTR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .mmio_wr_valid(mmio_wr_valid), .mmio_wr_idx(mmio_wr_idx), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_valid(mmio_rd_valid), .mmio_rd_idx(mmio_rd_idx), .mmio_rd_tid(mmio_rd_tid),
    .rsp_ready(rsp_ready), .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .vtp_mode(vtp_mode), .vtp_pt_base(vtp_pt_base), .vtp_pt_base_valid(vtp_pt_base_valid),
    .vc_map_ctrl(vc_map_ctrl), .vc_map_ctrl_valid(vc_map_ctrl_valid),
    .vc_map_history(vc_map_history), .wro_stats(wro_stats), .events(events),
    .rd_overflow(rd_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_rsp observed tid=%0h expected no response", rsp_tid);
      end
      if (sb.size() != 0) begin
        logic [72:0] e;
        e = sb.pop_front();
        check("rsp_tid", 64'(rsp_tid), 64'(e[72:64]));
        check("rsp_data", rsp_data, e[63:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [63:0] data);
    mmio_wr_valid = 1'b1;
    mmio_wr_idx   = idx;
    mmio_wr_data  = data;
    tick();
    mmio_wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [8:0] tid, input logic [63:0] exp, input bit expect_rsp);
    mmio_rd_valid = 1'b1;
    mmio_rd_idx   = idx;
    mmio_rd_tid   = tid;
    if (expect_rsp) sb.push_back({tid, exp});
    tick();
    mmio_rd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    tick();
    tick();
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  localparam logic [63:0] PT_BASE = 64'h3FF_1234_5678;
  localparam logic [63:0] MODE_A  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] MODE_B  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CTRL_A  = 64'h0000_00AA_5555_0001;
  localparam logic [63:0] CTRL_B  = 64'hFFFF_0000_1111_2222;
  localparam logic [63:0] HIST    = 64'h0BAD_F00D_0000_0042;

  initial begin
    reset_n        = 1'b0;
    mmio_wr_valid  = 1'b0;
    mmio_wr_idx    = '0;
    mmio_wr_data   = '0;
    mmio_rd_valid  = 1'b0;
    mmio_rd_idx    = '0;
    mmio_rd_tid    = '0;
    rsp_ready      = 1'b1;
    vc_map_history = HIST;
    wro_stats      = {64'h44, 64'h33, 64'h22, 64'h11};
    events         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vtp_mode", vtp_mode, 64'd0);
    check("reset_pt_base", 64'(vtp_pt_base), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_overflow", 64'(rd_overflow), 64'd0);
    reset_n = 1'b1;
    tick();

    // Page-table base write and its single-cycle pulse
    check("pt_valid_before", 64'(vtp_pt_base_valid), 64'd0);
    wr(4'd1, PT_BASE);
    check("pt_valid_n1", 64'(vtp_pt_base_valid), 64'd1);
    check("pt_base", 64'(vtp_pt_base), PT_BASE);
    tick();
    check("pt_valid_n2", 64'(vtp_pt_base_valid), 64'd0);

    // Back-to-back VC map control writes: one pulse each
    wr(4'd2, CTRL_A);
    check("ctrl_valid_a", 64'(vc_map_ctrl_valid), 64'd1);
    check("ctrl_a", vc_map_ctrl, CTRL_A);
    wr(4'd2, CTRL_B);
    check("ctrl_valid_b", 64'(vc_map_ctrl_valid), 64'd1);
    check("ctrl_b", vc_map_ctrl, CTRL_B);
    tick();
    check("ctrl_valid_off", 64'(vc_map_ctrl_valid), 64'd0);

    wr(4'd0, MODE_A);
    wr(4'd3, 64'hFFFF);
    wr(4'd4, 64'hFFFF);

    // Minimum latency read
    rd(4'd0, 9'h1A5, MODE_A, 1'b1);
    check("lat_n1_idle", 64'(rsp_valid), 64'd0);
    tick();
    check("lat_n2_valid", 64'(rsp_valid), 64'd1);
    check("lat_n2_tid", 64'(rsp_tid), 64'h1A5);
    drain("drain_latency");

    // Streaming reads across the index map
    rd(4'd1, 9'h010, PT_BASE, 1'b1);
    rd(4'd2, 9'h011, CTRL_B, 1'b1);
    rd(4'd3, 9'h012, HIST, 1'b1);
    rd(4'd4, 9'h013, 64'h11, 1'b1);
    rd(4'd5, 9'h014, 64'h22, 1'b1);
    rd(4'd6, 9'h015, 64'h33, 1'b1);
    rd(4'd7, 9'h016, 64'h44, 1'b1);
    rd(4'd15, 9'h017, 64'd0, 1'b1);
    drain("drain_map");

    // Same-cycle write and read of one index returns new data
    mmio_wr_valid = 1'b1;
    mmio_wr_idx   = 4'd0;
    mmio_wr_data  = MODE_B;
    rd(4'd0, 9'h0C3, MODE_B, 1'b1);
    mmio_wr_valid = 1'b0;
    drain("drain_rw_same");

    // Overflow: four fit, fifth dropped, then full push+pop accepted
    rsp_ready = 1'b0;
    rd(4'd0, 9'd1, MODE_B, 1'b1);
    rd(4'd0, 9'd2, MODE_B, 1'b1);
    rd(4'd0, 9'd3, MODE_B, 1'b1);
    rd(4'd0, 9'd4, MODE_B, 1'b1);
    check("ovf_not_yet", 64'(rd_overflow), 64'd0);
    rd(4'd0, 9'd5, MODE_B, 1'b0);
    check("ovf_set", 64'(rd_overflow), 64'd1);
    rsp_ready = 1'b1;
    rd(4'd0, 9'd6, MODE_B, 1'b1);
    drain("drain_overflow");
    check("ovf_sticky", 64'(rd_overflow), 64'd1);

    // Event counting and clear-over-event
    events = 7'h01;
    repeat (10) tick();
    events = 7'h00;
    rd(4'd8, 9'h080, 64'd10, 1'b1);
    drain("drain_ev10");
    events = 7'h03;
    wr(4'd15, 64'h1);
    events = 7'h00;
    rd(4'd8, 9'h081, 64'd0, 1'b1);
    rd(4'd9, 9'h082, 64'd1, 1'b1);
    drain("drain_clear");

    // Counter wrap at 2^CTR_W-1
    events = 7'h04;
    repeat ((1 << CTR_W) - 1) tick();
    events = 7'h00;
    rd(4'd10, 9'h0A0, 64'((1 << CTR_W) - 1), 1'b1);
    drain("drain_ctr_max");
    events = 7'h04;
    tick();
    events = 7'h00;
    rd(4'd10, 9'h0A1, 64'd0, 1'b1);
    drain("drain_wrap");

    // Reset mid-operation discards queued reads
    rsp_ready = 1'b0;
    rd(4'd0, 9'h101, 64'd0, 1'b0);
    rd(4'd1, 9'h102, 64'd0, 1'b0);
    rd(4'd2, 9'h103, 64'd0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_mode", vtp_mode, 64'd0);
    check("async_rst_ovf", 64'(rd_overflow), 64'd0);
    check("async_rst_ctrl", vc_map_ctrl, 64'd0);
    mmio_rd_valid = 1'b1;
    mmio_rd_idx   = 4'd0;
    mmio_rd_tid   = 9'h1FF;
    mmio_wr_valid = 1'b1;
    mmio_wr_idx   = 4'd0;
    mmio_wr_data  = MODE_A;
    rsp_ready     = 1'b1;
    tick();
    tick();
    mmio_rd_valid = 1'b0;
    mmio_wr_valid = 1'b0;
    reset_n       = 1'b1;
    repeat (10) tick();
    check("post_rst_mode", vtp_mode, 64'd0);
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    rd(4'd0, 9'h120, 64'd0, 1'b1);
    rd(4'd1, 9'h121, 64'd0, 1'b1);
    rd(4'd2, 9'h122, 64'd0, 1'b1);
    for (int i = 8; i < 15; i++) rd(4'(i), 9'(9'h130 + i), 64'd0, 1'b1);
    drain("drain_post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cci_mpf_csr_mmio_seq.md
CCI_MPF_CSR_MMIO_SEQ -- requirements
Module: cci_mpf_csr_mmio_seq

Interface
REQ-001 Parameter: RD_FIFO_DEPTH, 4, MMIO read requests buffered (power of 2, >=2).
REQ-002 Parameter: CTR_WIDTH, 48, event counter width, zero-extended to 64 on read.
REQ-003 Port: clk  in  1  sole clock; all state on rising edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: mmio_wr_valid/mmio_wr_idx/mmio_wr_data  in  1/4/64  host CSR write, no flow control.
REQ-006 Port: mmio_rd_valid/mmio_rd_idx/mmio_rd_tid  in  1/4/9  host CSR read, no flow control.
REQ-007 Port: rsp_ready  in  1  response channel can accept this cycle.
REQ-008 Port: rsp_valid/rsp_tid/rsp_data  out  1/9/64  read response.
REQ-009 Port: vtp_mode  out  64  page-table mode register.
REQ-010 Port: vtp_pt_base/vtp_pt_base_valid  out  42/1  page-table base line address; one-cycle valid pulse.
REQ-011 Port: vc_map_ctrl/vc_map_ctrl_valid  out  64/1  VC map control; one-cycle valid pulse.
REQ-012 Port: vc_map_history  in  64  VC map history status.
REQ-013 Port: wro_stats  in  4x64  writes, reads, write conflicts, read conflicts.
REQ-014 Port: events  in  7  [0]4KB hit,[1]4KB miss,[2]2MB hit,[3]2MB miss,[4]PT walk busy,[5]failed xlate,[6]VC map changed.
REQ-015 Port: rd_overflow  out  1  sticky: a read request was dropped.

Function
REQ-016 Index map: 0 vtp_mode RW; 1 vtp_pt_base RW (data[41:0]); 2 vc_map_ctrl RW; 3 vc_map_history RO; 4-7 wro_stats[0..3] RO; 8-14 event counters 0-6 RO; 15 counter-clear, write-only, reads return 0x0.
REQ-017 Writes to RO indices SHALL be ignored; reads of index 15 SHALL return 0.
REQ-018 Write at cycle N SHALL update the register at the end of N; vtp_pt_base_valid / vc_map_ctrl_valid SHALL pulse high exactly in cycle N+1 for writes to index 1 / 2.
REQ-019 Back-to-back writes to index 1 or 2 SHALL produce one valid pulse per write, each carrying that write's data.
REQ-020 Each read request SHALL be pushed as {idx,tid} into a FIFO of RD_FIFO_DEPTH entries at the end of its arrival cycle.
REQ-021 Read arriving with FIFO full and no pop in the same cycle SHALL be dropped and SHALL set rd_overflow; simultaneous push and pop when full SHALL be accepted.
REQ-022 FIFO head SHALL pop in any cycle where it is non-empty and rsp_ready=1; data SHALL be sampled from register/input state in the pop cycle.
REQ-023 rsp_valid SHALL be high for exactly the cycle after a pop, with the popped tid and sampled data; at most one response per cycle.
REQ-024 Minimum latency: request in cycle N, rsp_valid in N+2 when rsp_ready=1 in N+1.
REQ-025 Responses SHALL return in request order; rsp_ready=0 SHALL stall pops and never drop entries.
REQ-026 Write and read to the same index in the same cycle: the response SHALL carry the new data.
REQ-027 Event counter i SHALL increment by 1 per cycle events[i]=1, wrapping 2^CTR_WIDTH-1 -> 0.
REQ-028 Write to index 15 SHALL zero counter i for each data[i]=1 (i<7); clear SHALL win over a simultaneous event.
REQ-029 FIFO pointers SHALL wrap modulo RD_FIFO_DEPTH; occupancy SHALL be a separate count 0..RD_FIFO_DEPTH.

Reset
REQ-030 reset_n=0 SHALL asynchronously force: all registers, counters, FIFO count, rd_overflow, rsp_valid, valid pulses to 0.
REQ-031 Reset mid-operation SHALL discard all queued reads; no response SHALL issue for pre-reset requests.
REQ-032 Requests presented while reset_n=0 SHALL be ignored.

Verification
REQ-033 Write idx1 data 0x3FF_1234_5678 at N -> vtp_pt_base=0x3FF_1234_5678, vtp_pt_base_valid high only in N+1.
REQ-034 Read idx0 tid 0x1A5 at N, rsp_ready=1 -> rsp_valid at N+2, rsp_tid=0x1A5, rsp_data=current vtp_mode.
REQ-035 rsp_ready=0; 5 reads tids 1-5 with depth 4 -> rd_overflow=1; after rsp_ready=1, responses tids 1-4 in order, tid 5 never.
REQ-036 events[0] high 10 cycles, then write idx15 data 0x1 in a cycle with events[0]=1 -> read idx8 returns 10 before clear, 0 after.
REQ-037 Preload counter to 2^48-1, one event -> read returns 0.
REQ-038 3 reads queued, reset_n pulsed low -> no rsp_valid afterward; all registers read back 0.
